// File: rtl/axis_txd_frame_streamer_pkg.sv
// rtl/axis_txd_frame_streamer_pkg.sv - shared constants, state types and helpers for the TXD streamer
package omnixtend_eth_pkg;

    localparam int AXIS_DATA_W   = 32;
    localparam int AXIS_KEEP_W   = 4;
    localparam int ETH_MIN_BYTES = 60;
    localparam int ETH_MIN_WORDS = 15;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } txd_state_t;

    typedef enum logic {
        WRITE,
        DISCARD
    } wr_state_t;

    // Zero every byte lane whose keep bit is clear.
    function automatic logic [AXIS_DATA_W-1:0] keep_mask(
        input logic [AXIS_DATA_W-1:0] i_data,
        input logic [AXIS_KEEP_W-1:0] i_keep
    );
        logic [AXIS_DATA_W-1:0] v_out;
        for (int i = 0; i < AXIS_KEEP_W; i++) begin
            v_out[8*i +: 8] = i_keep[i] ? i_data[8*i +: 8] : 8'h00;
        end
        return v_out;
    endfunction

endpackage

// File: rtl/axis_txd_frame_streamer_if.sv
// rtl/axis_txd_frame_streamer_if.sv - AXI-Stream style bundle (tdata/tkeep/tvalid/tlast/tready)
// master drives tdata/tkeep/tvalid/tlast and samples tready; slave is the mirror image.
interface axis_txd_frame_streamer_if;
    import omnixtend_eth_pkg::*;

    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_txd_frame_streamer_sf.sv
// rtl/axis_txd_frame_streamer_sf.sv - frame buffer with commit/rewind frame-start pointer
// Module axis_txd_sf_fifo.
// Ports: i_clk, i_rst (async, active-high); i_wr_en/i_wr_data write one word;
// i_commit marks the word written this cycle as the end of a frame; i_rewind drops
// the uncommitted tail; i_rd_en pops o_rd_data (combinational read of the head);
// o_full / o_empty compare the write and read pointers.
module axis_txd_sf_fifo #(
    parameter int DEPTH = 512,
    parameter int W     = 37
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_commit,
    input  logic         i_rewind,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_start_ptr;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_start_ptr <= '0;
        end else begin
            if (i_rewind) begin
                r_wr_ptr <= r_start_ptr;
            end else if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            // Commit is raised together with the tlast write, so the frame
            // boundary sits just past the word being written.
            if (i_commit) begin
                r_start_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/axis_txd_frame_streamer.sv
// rtl/axis_txd_frame_streamer.sv - store-and-forward TX stage with inter-frame gap
// Frames from s_axis are buffered and released on m_axis_txd only once complete,
// so tvalid never drops mid-frame; after every frame tvalid is held low for
// IFG_CYCLES cycles so the downstream control generator sees a fresh rising edge.
// Ports: axis_clk, axis_reset (async, active-high); s_axis (slave stream in);
// m_axis_txd (master stream out); frame_drop (pulse when an oversize frame ends);
// frames_stored (complete frames resident).
// Optional macro TXD_MIN_PAD_EN: zero-pad frames shorter than 60 bytes to 15 words.
module axis_txd_frame_streamer
    import omnixtend_eth_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int IFG_CYCLES = 4,
    parameter int MAX_FRAMES = 16
) (
    input  logic                             axis_clk,
    input  logic                             axis_reset,
    axis_txd_frame_streamer_if.slave         s_axis,
    axis_txd_frame_streamer_if.master        m_axis_txd,
    output logic                             frame_drop,
    output logic [$clog2(MAX_FRAMES+1)-1:0]  frames_stored
);
    localparam int FW     = $clog2(MAX_FRAMES+1);
    localparam int GW     = $clog2(IFG_CYCLES+1);
    localparam int FIFO_W = AXIS_DATA_W + AXIS_KEEP_W + 1;

    wr_state_t              r_wr_state;
    txd_state_t             r_rd_state;
    logic [FW-1:0]          r_frames;
    logic [GW-1:0]          r_gap;
    logic [AXIS_DATA_W-1:0] r_tdata;
    logic [AXIS_KEEP_W-1:0] r_tkeep;
    logic                   r_tvalid;
    logic                   r_tlast;

    logic                   w_full;
    logic                   w_empty;
    logic [FIFO_W-1:0]      w_rd_word;
    logic                   w_oversize;
    logic                   w_s_ready;
    logic                   w_accept;
    logic                   w_wr_en;
    logic                   w_commit;
    logic                   w_drop;
    logic                   w_tlast_hs;
    logic                   w_load_first;
    logic                   w_load_next;
    logic                   w_rd_en;
    logic [AXIS_DATA_W-1:0] w_nx_tdata;
    logic [AXIS_KEEP_W-1:0] w_nx_tkeep;
    logic                   w_nx_tlast;

    // Write side. A full buffer with no committed frame can only hold the
    // current frame, which can never fit: drop it and sink the rest of it.
    assign w_oversize = (r_wr_state == WRITE) && w_full && (r_frames == '0);
    assign w_s_ready  = !axis_reset &&
                        ((r_wr_state == DISCARD) || w_oversize ||
                         (!w_full && (r_frames < FW'(MAX_FRAMES))));
    assign w_accept   = s_axis.tvalid && w_s_ready;
    assign w_wr_en    = w_accept && (r_wr_state == WRITE) && !w_oversize;
    assign w_commit   = w_wr_en && s_axis.tlast;
    assign w_drop     = w_accept && s_axis.tlast && ((r_wr_state == DISCARD) || w_oversize);

    assign s_axis.tready = w_s_ready;
    assign frame_drop    = w_drop;
    assign frames_stored = r_frames;

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_wr_state <= WRITE;
        end else begin
            case (r_wr_state)
                WRITE:   if (w_oversize && !(s_axis.tvalid && s_axis.tlast)) r_wr_state <= DISCARD;
                DISCARD: if (w_accept && s_axis.tlast) r_wr_state <= WRITE;
                default: r_wr_state <= WRITE;
            endcase
        end
    end

    // Read side.
    assign w_tlast_hs   = (r_rd_state == SEND) && r_tvalid && m_axis_txd.tready && r_tlast;
    assign w_load_next  = (r_rd_state == SEND) && r_tvalid && m_axis_txd.tready && !r_tlast;
    // GAP may hand straight over to SEND on its final cycle so the low time
    // between bursts is exactly IFG_CYCLES.
    assign w_load_first = (r_frames != '0) && !w_empty &&
                          (((r_rd_state == IDLE) && (r_gap == '0)) ||
                           ((r_rd_state == GAP) && (r_gap == GW'(1))));

`ifdef TXD_MIN_PAD_EN
    logic [3:0] r_beat;
    logic       r_pad;
    logic [3:0] w_nx_beat;
    logic       w_pad_now;
    logic       w_nx_pad;

    assign w_nx_beat = w_load_first ? 4'd0 : ((r_beat == 4'hF) ? 4'hF : r_beat + 4'd1);
    assign w_pad_now = r_pad && !w_load_first;
    // Pad words are synthesised, so the buffer is not popped for them.
    assign w_rd_en   = w_load_first || (w_load_next && !r_pad);

    always_comb begin
        w_nx_tdata = w_rd_word[AXIS_DATA_W-1:0];
        w_nx_tkeep = w_rd_word[AXIS_DATA_W +: AXIS_KEEP_W];
        w_nx_tlast = w_rd_word[FIFO_W-1];
        w_nx_pad   = 1'b0;
        if (w_pad_now) begin
            w_nx_tdata = '0;
            w_nx_tkeep = '1;
            w_nx_tlast = (w_nx_beat == 4'(ETH_MIN_WORDS-1));
            w_nx_pad   = 1'b1;
        end else if (w_rd_word[FIFO_W-1] && (w_nx_beat <= 4'(ETH_MIN_WORDS-1))) begin
            // Short frame: blank unused lanes of the last stored word, widen keep.
            w_nx_tdata = keep_mask(w_rd_word[AXIS_DATA_W-1:0], w_rd_word[AXIS_DATA_W +: AXIS_KEEP_W]);
            w_nx_tkeep = '1;
            w_nx_tlast = (w_nx_beat == 4'(ETH_MIN_WORDS-1));
            w_nx_pad   = (w_nx_beat < 4'(ETH_MIN_WORDS-1));
        end
    end
`else
    assign w_rd_en = w_load_first || w_load_next;

    always_comb begin
        w_nx_tdata = w_rd_word[AXIS_DATA_W-1:0];
        w_nx_tkeep = w_rd_word[AXIS_DATA_W +: AXIS_KEEP_W];
        w_nx_tlast = w_rd_word[FIFO_W-1];
    end
`endif

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_rd_state <= IDLE;
            r_gap      <= '0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
`ifdef TXD_MIN_PAD_EN
            r_beat     <= '0;
            r_pad      <= 1'b0;
`endif
        end else begin
            if (w_load_first || w_load_next) begin
                r_tdata  <= w_nx_tdata;
                r_tkeep  <= w_nx_tkeep;
                r_tlast  <= w_nx_tlast;
                r_tvalid <= 1'b1;
`ifdef TXD_MIN_PAD_EN
                r_beat   <= w_nx_beat;
                r_pad    <= w_nx_pad;
`endif
            end
            case (r_rd_state)
                IDLE: begin
                    if (w_load_first) r_rd_state <= SEND;
                end
                SEND: begin
                    if (w_tlast_hs) begin
                        r_rd_state <= GAP;
                        r_gap      <= GW'(IFG_CYCLES);
                        r_tvalid   <= 1'b0;
                        r_tdata    <= '0;
                        r_tkeep    <= '0;
                        r_tlast    <= 1'b0;
`ifdef TXD_MIN_PAD_EN
                        r_pad      <= 1'b0;
`endif
                    end
                end
                GAP: begin
                    if (r_gap > GW'(1)) begin
                        r_gap <= r_gap - GW'(1);
                    end else begin
                        r_gap      <= '0;
                        r_rd_state <= w_load_first ? SEND : IDLE;
                    end
                end
                default: r_rd_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            r_frames <= '0;
        end else begin
            case ({w_commit, w_tlast_hs})
                2'b10:   r_frames <= r_frames + FW'(1);
                2'b01:   r_frames <= r_frames - FW'(1);
                default: r_frames <= r_frames;
            endcase
        end
    end

    assign m_axis_txd.tdata  = r_tdata;
    assign m_axis_txd.tkeep  = r_tkeep;
    assign m_axis_txd.tvalid = r_tvalid;
    assign m_axis_txd.tlast  = r_tlast;

    axis_txd_sf_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .i_clk     (axis_clk),
        .i_rst     (axis_reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data ({s_axis.tlast, s_axis.tkeep, s_axis.tdata}),
        .i_commit  (w_commit),
        .i_rewind  (w_oversize),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_word),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_axis_txd_frame_streamer.sv
// tb/tb_axis_txd_frame_streamer.sv - scoreboard bench for axis_txd_frame_streamer
module tb_axis_txd_frame_streamer;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic [4:0] fs0, fs1;
    logic drop0, drop1;
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int mode = 0;

    beat_t q0[$];
    beat_t q1[$];

    axis_txd_frame_streamer_if s0();
    axis_txd_frame_streamer_if m0();
    axis_txd_frame_streamer_if s1();
    axis_txd_frame_streamer_if m1();

    axis_txd_frame_streamer dut (
        .axis_clk(clk), .axis_reset(rst0), .s_axis(s0), .m_axis_txd(m0),
        .frame_drop(drop0), .frames_stored(fs0)
    );

    axis_txd_frame_streamer #(.DEPTH(16)) dut_s (
        .axis_clk(clk), .axis_reset(rst1), .s_axis(s1), .m_axis_txd(m1),
        .frame_drop(drop1), .frames_stored(fs1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int base, input int i);
        return {8'hA5, 8'hC3, 8'(base), 8'(i + 1)};
    endfunction

    function automatic int exp_beats(input int n, input logic [3:0] lk);
        int bytes;
        bytes = 4 * (n - 1) + $countones(lk);
`ifdef TXD_MIN_PAD_EN
        return (bytes < 60) ? 15 : n;
`else
        return (bytes > 0) ? n : 0;
`endif
    endfunction

    task automatic push_expected(input bit sel, input int n, input logic [3:0] lk, input int base);
        beat_t tmp[$];
        beat_t b;
        int bytes;
        bytes = 4 * (n - 1) + $countones(lk);
        for (int i = 0; i < n; i++) begin
            b.d = word_of(base, i);
            b.k = (i == n - 1) ? lk : 4'hF;
            b.l = (i == n - 1);
`ifdef TXD_MIN_PAD_EN
            if (bytes < 60) begin
                for (int j = 0; j < 4; j++) if (!b.k[j]) b.d[8*j +: 8] = 8'h00;
                b.k = 4'hF;
                b.l = 1'b0;
            end
`endif
            tmp.push_back(b);
        end
`ifdef TXD_MIN_PAD_EN
        if (bytes < 60) begin
            for (int i = n; i < 15; i++) tmp.push_back('{d: 32'h0, k: 4'hF, l: 1'b0});
            tmp[tmp.size() - 1].l = 1'b1;
        end
`endif
        foreach (tmp[i]) begin
            if (sel) q1.push_back(tmp[i]);
            else     q0.push_back(tmp[i]);
        end
    endtask

    task automatic drive_word(input bit sel, input logic [31:0] d, input logic [3:0] k, input logic l,
                              output int acc_cyc, inout int stalls);
        bit ok;
        int t;
        t = 0;
        if (sel) begin s1.tdata = d; s1.tkeep = k; s1.tlast = l; s1.tvalid = 1'b1; end
        else     begin s0.tdata = d; s0.tkeep = k; s0.tlast = l; s0.tvalid = 1'b1; end
        do begin
            @(negedge clk);
            ok = sel ? s1.tready : s0.tready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (!ok) stalls++;
            t++;
        end while (!ok && t < 2000);
        if (!ok) check("wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input bit sel, input int n, input logic [3:0] lk, input int base,
                              input bit expect_out, output int last_cy, output int stalls);
        stalls = 0;
        last_cy = 0;
        if (expect_out) push_expected(sel, n, lk, base);
        for (int i = 0; i < n; i++) begin
            drive_word(sel, word_of(base, i), (i == n - 1) ? lk : 4'hF, (i == n - 1), last_cy, stalls);
        end
        if (sel) s1.tvalid = 1'b0;
        else     s0.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input bit sel);
        int t;
        t = 0;
        while ((sel ? q1.size() : q0.size()) != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        check(sel ? "drain1" : "drain0", sel ? q1.size() : q0.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // MAC ready for the main instance: steady or toggling every cycle.
    initial begin
        m0.tready = 1'b1;
        m1.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m0.tready = (mode == 1) ? ~m0.tready : 1'b1;
        end
    end

    // Monitor for the main instance.
    bit in_frame0 = 0, prev_v0 = 0, have_tlast0 = 0;
    int rises0 = 0, rise_cyc0 = 0, tlast_cyc0 = 0, gap_low0 = 0, burst0 = 0, last_burst0 = 0, pops0 = 0;
    logic [15:0] hist0 = '0;
    logic [4:0] prev_fs0 = '0;
    beat_t e0;

    always @(negedge clk) begin
        if (rst0) begin
            in_frame0 = 0;
            prev_v0 = 0;
            have_tlast0 = 0;
        end else begin
            if (m0.tvalid && !prev_v0) begin
                rises0++;
                rise_cyc0 = cyc;
                if (have_tlast0) gap_low0 = cyc - tlast_cyc0 - 1;
                burst0 = 0;
            end
            if (in_frame0) check("tvalid_hold", {31'd0, m0.tvalid}, 32'd1);
            if (m0.tvalid) burst0++;
            if (m0.tvalid && m0.tready) begin
                if (q0.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    pops0++;
                    check("tdata", m0.tdata, e0.d);
                    check("tkeep", {28'd0, m0.tkeep}, {28'd0, e0.k});
                    check("tlast", {31'd0, m0.tlast}, {31'd0, e0.l});
                end
                in_frame0 = !m0.tlast;
                if (m0.tlast) begin
                    tlast_cyc0 = cyc;
                    have_tlast0 = 1;
                    last_burst0 = burst0;
                end
            end else if (m0.tvalid && q0.size() != 0) begin
                check("stall_tdata", m0.tdata, q0[0].d);
                check("stall_tkeep", {28'd0, m0.tkeep}, {28'd0, q0[0].k});
            end
            prev_v0 = m0.tvalid;
        end
        if (fs0 != prev_fs0) begin
            hist0 = {hist0[11:0], fs0[3:0]};
            prev_fs0 = fs0;
        end
    end

    // Monitor for the DEPTH=16 instance.
    bit prev_v1 = 0;
    int rises1 = 0, drop_cnt1 = 0, drop_cyc1 = -1;
    beat_t e1;

    always @(negedge clk) begin
        if (rst1) begin
            prev_v1 = 0;
        end else begin
            if (m1.tvalid && !prev_v1) rises1++;
            if (drop1) begin
                drop_cnt1++;
                drop_cyc1 = cyc;
            end
            if (m1.tvalid && m1.tready) begin
                if (q1.size() == 0) begin
                    check("unexpected_beat_s", 32'd1, 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    check("tdata_s", m1.tdata, e1.d);
                    check("tkeep_s", {28'd0, m1.tkeep}, {28'd0, e1.k});
                    check("tlast_s", {31'd0, m1.tlast}, {31'd0, e1.l});
                end
            end
            prev_v1 = m1.tvalid;
        end
    end

    int last_cy, stalls, r_before, p_before, t;

    initial begin
        s0.tvalid = 0; s0.tdata = 0; s0.tkeep = 0; s0.tlast = 0;
        s1.tvalid = 0; s1.tdata = 0; s1.tkeep = 0; s1.tlast = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", {31'd0, m0.tvalid}, 32'd0);
        check("rst_tdata", m0.tdata, 32'd0);
        check("rst_tkeep", {28'd0, m0.tkeep}, 32'd0);
        check("rst_tlast", {31'd0, m0.tlast}, 32'd0);
        check("rst_s_tready", {31'd0, s0.tready}, 32'd0);
        check("rst_frames", {27'd0, fs0}, 32'd0);
        check("rst_drop", {31'd0, drop0}, 32'd0);
        rst0 = 0;
        rst1 = 0;
        #1;
        check("rel_s_tready", {31'd0, s0.tready}, 32'd1);
        check("rel_s_tready_s", {31'd0, s1.tready}, 32'd1);
        @(posedge clk);
        #1;

        // Single 4-word frame, last keep 3.
        r_before = rises0;
        send_frame(0, 4, 4'h3, 8'h10, 1, last_cy, stalls);
        wait_drain(0);
        check("latency_4w", rise_cyc0 - last_cy, 2);
        check("burst_4w", last_burst0, exp_beats(4, 4'h3));
        repeat (6) @(posedge clk);
        #1;
        check("no_rise_in_gap", rises0, r_before + 1);
        check("gap_tvalid_low", {31'd0, m0.tvalid}, 32'd0);

        // Two back-to-back 16-word frames.
        hist0 = '0;
        send_frame(0, 16, 4'hF, 8'h20, 1, last_cy, stalls);
        send_frame(0, 16, 4'hF, 8'h21, 1, last_cy, stalls);
        wait_drain(0);
        check("ifg_low_cycles", gap_low0, 4);
        check("frames_hist", {16'd0, hist0}, 32'h1210);
        check("burst_16w", last_burst0, 16);

        // 20-word frame with MAC ready toggling.
        mode = 1;
        send_frame(0, 20, 4'hF, 8'h30, 1, last_cy, stalls);
        wait_drain(0);
        mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Oversize frame into the 16-word instance, then a normal frame.
        send_frame(1, 20, 4'hF, 8'h40, 0, last_cy, stalls);
        check("ovs_stalls", stalls, 0);
        repeat (4) @(posedge clk);
        #1;
        check("ovs_drop_cnt", drop_cnt1, 1);
        check("ovs_drop_cyc", drop_cyc1, last_cy);
        check("ovs_frames", {27'd0, fs1}, 32'd0);
        check("ovs_no_txd", rises1, 0);
        send_frame(1, 3, 4'h3, 8'h50, 1, last_cy, stalls);
        wait_drain(1);
        check("ovs_next_rises", rises1, 1);
        check("ovs_drop_after", drop_cnt1, 1);

        // Short frame: 3 words, last keep 1.
        repeat (6) @(posedge clk);
        #1;
        send_frame(0, 3, 4'h1, 8'h60, 1, last_cy, stalls);
        wait_drain(0);
        check("short_burst", last_burst0, exp_beats(3, 4'h1));

        // Reset during beat 5 of a 10-word frame.
        repeat (6) @(posedge clk);
        #1;
        p_before = pops0;
        send_frame(0, 10, 4'hF, 8'h70, 1, last_cy, stalls);
        t = 0;
        while (pops0 < p_before + 4 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("pre_rst_pops", pops0 - p_before, 4);
        #3;
        rst0 = 1;
        #1;
        check("rst_mid_tvalid", {31'd0, m0.tvalid}, 32'd0);
        check("rst_mid_frames", {27'd0, fs0}, 32'd0);
        check("rst_mid_s_tready", {31'd0, s0.tready}, 32'd0);
        q0.delete();
        repeat (3) @(posedge clk);
        #1;
        rst0 = 0;
        #1;
        check("post_rst_s_tready", {31'd0, s0.tready}, 32'd1);
        @(posedge clk);
        #1;
        send_frame(0, 3, 4'hF, 8'h80, 1, last_cy, stalls);
        wait_drain(0);
        check("post_rst_latency", rise_cyc0 - last_cy, 2);
        check("post_rst_burst", last_burst0, exp_beats(3, 4'hF));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_txd_frame_streamer.md
Name: axis_txd_frame_streamer

Overview:
- Store-and-forward TX data stage directly upstream of the AXI Ethernet TX control generator and the MAC TX data port.
- Buffers one or more complete frames from the OmniXtend framing logic (s_axis).
- Emits each frame on m_axis_txd only when the whole frame is resident, so tvalid never drops mid-frame.
- Enforces a tvalid-low inter-frame gap. The downstream control generator needs this gap to detect a rising edge of m_axis_txd_tvalid for every frame.

Parameters:
- DEPTH, 512, buffer depth in 32-bit words (power of two, minimum 16).
- IFG_CYCLES, 4, cycles m_axis_txd_tvalid is held low after each tlast handshake (minimum 2).
- MAX_FRAMES, 16, maximum complete frames held simultaneously.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_reset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  32  frame payload word.
- s_axis_tkeep  in  4  byte enables. Legal values are 4'hF on non-last words and 4'h1/3/7/F on the last word.
- s_axis_tvalid  in  1  upstream word valid.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tready  out  1  buffer accepting.
- m_axis_txd_tdata  out  32  frame word to MAC.
- m_axis_txd_tkeep  out  4  byte enables to MAC.
- m_axis_txd_tvalid  out  1  word valid to MAC and to the TX control generator.
- m_axis_txd_tlast  out  1  last word of frame.
- m_axis_txd_tready  in  1  MAC accepting.
- frame_drop  out  1  one-cycle pulse when an oversize frame is discarded.
- frames_stored  out  $clog2(MAX_FRAMES+1)  count of complete frames resident.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - All m_axis_txd_* outputs are 0.
  - s_axis_tready=0 during reset and 1 from the first cycle after release.
  - frame_drop=0, frames_stored=0, pointers cleared, FSM=IDLE.
  - The gap counter is preloaded so the first frame may start without a gap.
- Write side:
  - A word is accepted when s_axis_tvalid && s_axis_tready.
  - s_axis_tready = !full && (frames_stored < MAX_FRAMES), except in DISCARD mode, where it is forced to 1.
  - A write with tlast commits the frame: the frame start pointer advances and frames_stored increments the next cycle.
- Oversize frame:
  - Trigger: the buffer is full, frames_stored==0, and the in-progress frame has no tlast yet.
  - Rewind the write pointer to the frame start and enter DISCARD.
  - In DISCARD, sink words with tready=1 until tlast. Pulse frame_drop in the tlast cycle, then resume normal writes.
- Read FSM:
  - IDLE -> SEND when frames_stored>0 and the gap counter has expired.
  - SEND: tvalid=1 and stays high until the tlast handshake. Data, keep and last are registered from the buffer and advance only on tready.
  - SEND -> GAP on the tlast handshake. frames_stored decrements in the same cycle.
  - GAP: tvalid=0 for exactly IFG_CYCLES cycles, then -> IDLE.
- Latency:
  - A tlast write at cycle N produces m_axis_txd_tvalid at N+2 at the earliest (buffer empty, gap expired).
- Simultaneous commit and tlast read in the same cycle: frames_stored is unchanged.
- Pointer wrap: pointers are $clog2(DEPTH)+1 bits.
  - full when MSBs differ and the rest are equal.
  - empty when the pointers are equal.
- Outputs stay stable while tvalid && !tready (AXI-Stream rule).
- A reset asserted mid-frame on either side aborts immediately. No partial frame is emitted after reset.

Optional Feature:
- Macro: TXD_MIN_PAD_EN.
- When defined, frames shorter than 60 bytes are zero-padded on output to exactly 15 words.
  - Missing bytes in a partial last stored word are zeroed and tkeep becomes 4'hF.
  - Zero words with tkeep=4'hF follow; tlast is on word 15.
  - Frames of 60 bytes or more pass unchanged.
- When undefined, frames are emitted exactly as stored.

Decomposition:
- Package omnixtend_eth_pkg:
  - constants AXIS_DATA_W=32, AXIS_KEEP_W=4, ETH_MIN_BYTES=60, ETH_MIN_WORDS=15.
  - typedef txd_state_t {IDLE, SEND, GAP}.
  - typedef wr_state_t {WRITE, DISCARD}.
- One sub-module, axis_txd_sf_fifo: a 37-bit-wide (data+keep+last) synchronous buffer with a commit/rewind frame-start pointer and full/empty flags.
- The streamer top holds both FSMs, the frame counter and the padding logic.

Test Plan:
- Single 4-word frame (tkeep F,F,F,3), MAC tready=1:
  - m_axis_txd_tvalid rises 2 cycles after the s tlast, with 4 contiguous beats and tlast on beat 4 with tkeep=3.
  - tvalid then stays low for 4 cycles.
- Two back-to-back 16-word frames, tready held high:
  - Two bursts separated by exactly IFG_CYCLES=4 tvalid-low cycles.
  - frames_stored goes 2->1->0.
- 20-word frame with tready toggling 1,0,1,0:
  - tvalid never drops mid-frame.
  - Data and keep stay stable during tready=0 cycles.
  - All 20 words arrive in order.
- DEPTH=16, 20-word frame with no tlast until word 20:
  - s_axis_tready stays high.
  - frame_drop pulses once on word 20.
  - frames_stored=0 and no txd output.
  - A following 3-word frame transmits normally.
- TXD_MIN_PAD_EN defined, 3-word frame with last tkeep=1 (9 bytes):
  - Output is 15 beats, all tkeep=F.
  - Bytes 9..59 are zero; tlast on beat 15.
- axis_reset asserted mid-SEND (beat 5 of 10):
  - tvalid=0 asynchronously and frames_stored=0.
  - After release no residual beats are emitted, and a new frame starts without a gap.
